// File: rtl/bnn_tile_mac_if.sv
// Handshake bundle for bnn_tile_mac: weight push, activation beats and result channel.
// The master side drives weights/activations and out_ready; the slave side is the MAC tile.
interface bnn_tile_mac_if #(
    parameter int DATA_WIDTH = 6,
    parameter int K          = 4,
    parameter int CH_NUM     = 6,
    parameter int ACC_WIDTH  = 12
);
    localparam int LANES = CH_NUM * K * K;

    logic                          mode;
    logic                          w_valid;
    logic                          w_ready;
    logic [LANES-1:0]              w_data;
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_last;
    logic [LANES*DATA_WIDTH-1:0]   in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [CH_NUM*ACC_WIDTH-1:0]   out_data;
    logic                          out_sat;
    logic                          busy;

    modport master (
        output mode, w_valid, w_data, in_valid, in_last, in_data, out_ready,
        input  w_ready, in_ready, out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  mode, w_valid, w_data, in_valid, in_last, in_data, out_ready,
        output w_ready, in_ready, out_valid, out_data, out_sat, busy
    );
endinterface

// File: rtl/bnn_tile_mac.sv
// Binary-weight MAC tile: 2-deep weight FIFO, conv (per-beat) and fc (accumulating) modes,
// saturating per-channel accumulators and a registered result with valid/ready backpressure.
module bnn_tile_mac #(
    parameter int DATA_WIDTH = 6,
    parameter int K          = 4,
    parameter int CH_NUM     = 6,
    parameter int ACC_WIDTH  = 12
) (
    input  logic           clk,
    input  logic           rstn,
    bnn_tile_mac_if.slave  bus
);
    localparam int KK     = K * K;
    localparam int LANES  = CH_NUM * KK;
    localparam int PSUM_W = DATA_WIDTH + $clog2(KK) + 1;
    localparam int SUM_W  = ((ACC_WIDTH > PSUM_W) ? ACC_WIDTH : PSUM_W) + 1;

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FC   = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [LANES-1:0]              r_wmem [2];
    logic                          r_wr_ptr;
    logic                          r_rd_ptr;
    logic [1:0]                    r_count;
    logic signed [ACC_WIDTH-1:0]   r_acc [CH_NUM];
    logic                          r_sat_grp;
    logic                          r_out_valid;
    logic                          r_out_sat;
    logic [CH_NUM*ACC_WIDTH-1:0]   r_out_data;

    logic                          w_in_ready;
    logic                          w_push;
    logic                          w_accept;
    logic                          w_mode_eff;
    logic                          w_produce;
    logic                          w_pop;
    logic [LANES-1:0]              w_head;
    logic signed [PSUM_W-1:0]      w_psum [CH_NUM];
    logic signed [SUM_W-1:0]       w_sum [CH_NUM];
    logic [ACC_WIDTH:0]            w_sat_pack [CH_NUM];
    logic signed [ACC_WIDTH-1:0]   w_res [CH_NUM];
    logic                          w_clamp_any;

    function automatic logic signed [PSUM_W-1:0] lane_ext(input logic [DATA_WIDTH-1:0] x);
        return {{(PSUM_W-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    endfunction

    function automatic logic signed [SUM_W-1:0] acc_ext(input logic [ACC_WIDTH-1:0] a);
        return {{(SUM_W-ACC_WIDTH){a[ACC_WIDTH-1]}}, a};
    endfunction

    function automatic logic signed [SUM_W-1:0] psum_ext(input logic [PSUM_W-1:0] p);
        return {{(SUM_W-PSUM_W){p[PSUM_W-1]}}, p};
    endfunction

    // Returns {clamped, value} with value limited to the signed ACC_WIDTH range.
    function automatic logic [ACC_WIDTH:0] sat_acc(input logic signed [SUM_W-1:0] v);
        logic [ACC_WIDTH:0] r;
        if (v > SAT_MAX) begin
            r = {1'b1, SAT_MAX[ACC_WIDTH-1:0]};
        end else if (v < SAT_MIN) begin
            r = {1'b1, SAT_MIN[ACC_WIDTH-1:0]};
        end else begin
            r = {1'b0, v[ACC_WIDTH-1:0]};
        end
        return r;
    endfunction

    assign w_in_ready = (r_count != 2'd0) && (!r_out_valid || bus.out_ready);
    assign w_push     = bus.w_valid && (r_count != 2'd2);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_head     = r_wmem[r_rd_ptr];
    assign w_produce  = w_accept && (!w_mode_eff || bus.in_last);
    assign w_pop      = w_accept && (w_mode_eff || bus.in_last);

    // Mode comes from the port only on the first beat; afterwards the group's mode is held.
    always_comb begin
        w_mode_eff = 1'b0;
        case (r_state)
            ST_IDLE: w_mode_eff = bus.mode;
            ST_CONV: w_mode_eff = 1'b0;
            ST_FC:   w_mode_eff = 1'b1;
            default: w_mode_eff = 1'b0;
        endcase
    end

    // Group tracking next state.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            if (bus.in_last) begin
                w_state_nxt = ST_IDLE;
            end else if (w_mode_eff) begin
                w_state_nxt = ST_FC;
            end else begin
                w_state_nxt = ST_CONV;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Full-precision partial sums, then saturating add onto the accumulator (fc) or zero (conv).
    always_comb begin
        w_clamp_any = 1'b0;
        for (int c = 0; c < CH_NUM; c++) begin
            w_psum[c] = {PSUM_W{1'b0}};
            for (int k = 0; k < KK; k++) begin
                if (w_head[c*KK+k]) begin
                    w_psum[c] = w_psum[c] + lane_ext(w_mode_eff ?
                        bus.in_data[(c*KK+k)*DATA_WIDTH +: DATA_WIDTH] :
                        bus.in_data[k*DATA_WIDTH +: DATA_WIDTH]);
                end else begin
                    w_psum[c] = w_psum[c] - lane_ext(w_mode_eff ?
                        bus.in_data[(c*KK+k)*DATA_WIDTH +: DATA_WIDTH] :
                        bus.in_data[k*DATA_WIDTH +: DATA_WIDTH]);
                end
            end
            w_sum[c]      = (w_mode_eff ? acc_ext(r_acc[c]) : {SUM_W{1'b0}}) + psum_ext(w_psum[c]);
            w_sat_pack[c] = sat_acc(w_sum[c]);
            w_res[c]      = w_sat_pack[c][ACC_WIDTH-1:0];
            w_clamp_any   = w_clamp_any | w_sat_pack[c][ACC_WIDTH];
        end
    end

    // Group state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Weight FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wmem[0] <= {LANES{1'b0}};
            r_wmem[1] <= {LANES{1'b0}};
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_wmem[r_wr_ptr] <= bus.w_data;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Accumulators and sticky group saturation; both clear when the group closes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < CH_NUM; c++) begin
                r_acc[c] <= {ACC_WIDTH{1'b0}};
            end
            r_sat_grp <= 1'b0;
        end else if (w_accept) begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (w_mode_eff && !bus.in_last) begin
                    r_acc[c] <= w_res[c];
                end else if (w_mode_eff) begin
                    r_acc[c] <= {ACC_WIDTH{1'b0}};
                end
            end
            r_sat_grp <= bus.in_last ? 1'b0 : (r_sat_grp | w_clamp_any);
        end
    end

    // Result register: loads on a producing beat, otherwise drains on out_ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
            r_out_data  <= {(CH_NUM*ACC_WIDTH){1'b0}};
        end else if (w_produce) begin
            r_out_valid <= 1'b1;
            r_out_sat   <= r_sat_grp | w_clamp_any;
            for (int c = 0; c < CH_NUM; c++) begin
                r_out_data[c*ACC_WIDTH +: ACC_WIDTH] <= w_res[c];
            end
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.w_ready   = (r_count != 2'd2);
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
    assign bus.busy      = (r_state == ST_FC);
endmodule

// File: tb/tb_bnn_tile_mac.sv
// Directed bench for bnn_tile_mac: single-beat vector table plus hand-written multi-cycle sequences.
module tb_bnn_tile_mac;
    localparam int DW  = 6;
    localparam int K   = 4;
    localparam int CH  = 6;
    localparam int ACC = 12;
    localparam int KK  = K * K;

    typedef struct {
        logic        mode;
        logic [15:0] wpat;
        int          x;
        int          y;
        int          e0;
        int          er;
        logic        sat;
    } vec_t;

    logic clk;
    logic rstn;
    int   n_pass;
    int   n_total;
    vec_t vecs [8];

    bnn_tile_mac_if #(.DATA_WIDTH(DW), .K(K), .CH_NUM(CH), .ACC_WIDTH(ACC)) bus ();

    bnn_tile_mac #(.DATA_WIDTH(DW), .K(K), .CH_NUM(CH), .ACC_WIDTH(ACC)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [CH*ACC-1:0] rep(input int e0, input int er);
        logic [CH*ACC-1:0] r;
        for (int c = 0; c < CH; c++) begin
            r[c*ACC +: ACC] = (c == 0) ? e0[ACC-1:0] : er[ACC-1:0];
        end
        return r;
    endfunction

    task automatic set_w(input logic [15:0] p);
        for (int c = 0; c < CH; c++) begin
            bus.w_data[c*KK +: KK] = p;
        end
    endtask

    task automatic set_lanes(input int x, input int y);
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < KK; k++) begin
                bus.in_data[(c*KK+k)*DW +: DW] = (c == 0) ? x[DW-1:0] : y[DW-1:0];
            end
        end
    endtask

    task automatic push_w(input logic [15:0] p);
        set_w(p);
        bus.w_valid = 1'b1;
        tick();
        bus.w_valid = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        //            mode  wpat      x    y   e0    er   sat
        vecs[0] = '{1'b0, 16'hffff,   1,   7,   16,   16, 1'b0};
        vecs[1] = '{1'b0, 16'h0000,   2,  -5,  -32,  -32, 1'b0};
        vecs[2] = '{1'b0, 16'h00ff,   5,   3,    0,    0, 1'b0};
        vecs[3] = '{1'b0, 16'h000f,  -3,   9,   24,   24, 1'b0};
        vecs[4] = '{1'b1, 16'hffff,  31,  -1,  496,  -16, 1'b0};
        vecs[5] = '{1'b1, 16'h0000,  31,   2, -496,  -32, 1'b0};
        vecs[6] = '{1'b1, 16'h0001, -32,   1,  448,  -14, 1'b0};
        vecs[7] = '{1'b1, 16'hffff, -32,   0, -512,    0, 1'b0};

        rstn          = 1'b0;
        bus.mode      = 1'b0;
        bus.w_valid   = 1'b0;
        bus.w_data    = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_w_ready", 128'(bus.w_ready), 128'(1'b1));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1'b0));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
        chk("rst_out_data", 128'(bus.out_data), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(1'b0));
        rstn = 1'b1;
        tick();
        chk("post_rst_in_ready", 128'(bus.in_ready), 128'(1'b0));

        // Single-beat groups from the table.
        for (int v = 0; v < 8; v++) begin
            push_w(vecs[v].wpat);
            chk($sformatf("v%0d_in_ready_pre", v), 128'(bus.in_ready), 128'(1'b1));
            bus.mode = vecs[v].mode;
            set_lanes(vecs[v].x, vecs[v].y);
            bus.in_valid = 1'b1;
            bus.in_last  = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            chk($sformatf("v%0d_out_valid", v), 128'(bus.out_valid), 128'(1'b1));
            chk($sformatf("v%0d_out_data", v), 128'(bus.out_data), 128'(rep(vecs[v].e0, vecs[v].er)));
            chk($sformatf("v%0d_out_sat", v), 128'(bus.out_sat), 128'(vecs[v].sat));
            chk($sformatf("v%0d_fifo_empty", v), 128'(bus.in_ready), 128'(1'b0));
            tick();
            chk($sformatf("v%0d_drained", v), 128'(bus.out_valid), 128'(1'b0));
        end

        // Conv reuse: one weight set serves three beats.
        push_w(16'h0000);
        bus.mode = 1'b0;
        set_lanes(2, 2);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_last = (i == 2);
            tick();
            chk($sformatf("reuse%0d_valid", i), 128'(bus.out_valid), 128'(1'b1));
            chk($sformatf("reuse%0d_data", i), 128'(bus.out_data), 128'(rep(-32, -32)));
            chk($sformatf("reuse%0d_in_ready", i), 128'(bus.in_ready), 128'(i < 2));
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        tick();

        // Fc: four beats, refilling the FIFO with simultaneous push/pop on beats 2 and 3.
        push_w(16'hffff);
        push_w(16'hffff);
        chk("fc_fifo_full", 128'(bus.w_ready), 128'(1'b0));
        bus.mode = 1'b1;
        set_lanes(2, 2);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_last = (i == 3);
            bus.w_valid = (i == 1 || i == 2);
            tick();
            bus.mode = 1'b0;
            if (i < 3) begin
                chk($sformatf("fc%0d_busy", i), 128'(bus.busy), 128'(1'b1));
                chk($sformatf("fc%0d_no_out", i), 128'(bus.out_valid), 128'(1'b0));
                chk($sformatf("fc%0d_in_ready", i), 128'(bus.in_ready), 128'(1'b1));
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.w_valid  = 1'b0;
        chk("fc_valid", 128'(bus.out_valid), 128'(1'b1));
        chk("fc_data", 128'(bus.out_data), 128'(rep(128, 128)));
        chk("fc_busy_done", 128'(bus.busy), 128'(1'b0));
        chk("fc_sat", 128'(bus.out_sat), 128'(1'b0));
        chk("fc_fifo_empty", 128'(bus.in_ready), 128'(1'b0));
        tick();

        // Saturation over five fc beats, then a clean group.
        push_w(16'hffff);
        bus.mode = 1'b1;
        set_lanes(-32, -32);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_last = (i == 4);
            bus.w_valid = (i < 4);
            tick();
            if (i < 4) begin
                chk($sformatf("sat%0d_no_out", i), 128'(bus.out_valid), 128'(1'b0));
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.w_valid  = 1'b0;
        chk("sat_valid", 128'(bus.out_valid), 128'(1'b1));
        chk("sat_data", 128'(bus.out_data), 128'(rep(-2048, -2048)));
        chk("sat_flag", 128'(bus.out_sat), 128'(1'b1));
        tick();
        push_w(16'hffff);
        set_lanes(1, 1);
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("clean_data", 128'(bus.out_data), 128'(rep(16, 16)));
        chk("clean_sat", 128'(bus.out_sat), 128'(1'b0));
        tick();

        // Backpressure: held result blocks the next beat until out_ready returns.
        push_w(16'hffff);
        push_w(16'hffff);
        bus.mode = 1'b0;
        set_lanes(1, 1);
        bus.in_valid  = 1'b1;
        bus.in_last   = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        set_lanes(3, 3);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_in_ready", i), 128'(bus.in_ready), 128'(1'b0));
            chk($sformatf("bp%0d_valid", i), 128'(bus.out_valid), 128'(1'b1));
            chk($sformatf("bp%0d_data", i), 128'(bus.out_data), 128'(rep(16, 16)));
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 128'(bus.in_ready), 128'(1'b1));
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("bp_next_valid", 128'(bus.out_valid), 128'(1'b1));
        chk("bp_next_data", 128'(bus.out_data), 128'(rep(48, 48)));
        chk("bp_fifo_empty", 128'(bus.in_ready), 128'(1'b0));
        tick();
        chk("bp_drained", 128'(bus.out_valid), 128'(1'b0));

        // Reset in the middle of an fc group discards the partial sum.
        push_w(16'hffff);
        push_w(16'hffff);
        bus.mode = 1'b1;
        set_lanes(1, 1);
        bus.in_valid = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("mid_busy", 128'(bus.busy), 128'(1'b1));
        rstn = 1'b0;
        #2;
        chk("mid_rst_valid", 128'(bus.out_valid), 128'(1'b0));
        chk("mid_rst_busy", 128'(bus.busy), 128'(1'b0));
        chk("mid_rst_w_ready", 128'(bus.w_ready), 128'(1'b1));
        chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(1'b0));
        chk("mid_rst_data", 128'(bus.out_data), 128'(0));
        chk("mid_rst_sat", 128'(bus.out_sat), 128'(1'b0));
        tick();
        rstn = 1'b1;
        tick();
        push_w(16'hffff);
        bus.mode = 1'b1;
        set_lanes(2, 2);
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("fresh_valid", 128'(bus.out_valid), 128'(1'b1));
        chk("fresh_data", 128'(bus.out_data), 128'(rep(32, 32)));
        chk("fresh_busy", 128'(bus.busy), 128'(1'b0));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
